mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the instruction-fetch stage and the data-memory stage of the pipelined core, enabling a unified instruction/data memory. Data requests have priority. A starvation counter guarantees that fetch makes progress. Per-stage stall outputs hold the pipeline while a request is pending.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the unified I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // Bits needed to hold a counter value in 0..max_val (never narrower than 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: data wins unless fetch has been starved too long.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned STARVE_W   = cnt_w(STARVE_MAX)
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_valid,
  output logic                grant_owner
);

  localparam bit FORCE_EN = (STARVE_MAX != 0);

  logic force_if;

  // Pick the winner; a saturated starvation count hands the port to fetch.
  always_comb begin
    force_if    = FORCE_EN && if_req && (starve_cnt == STARVE_W'(STARVE_MAX));
    grant_valid = if_req | d_req;
    grant_owner = (d_req && !force_if) ? OWNER_D : OWNER_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch and data stages.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned LAT_W    = cnt_w(MEM_LAT);
  localparam int unsigned STARVE_W = cnt_w(STARVE_MAX);

  state_t              state, state_nxt;
  logic                owner, owner_nxt;
  logic [LAT_W-1:0]    lat_cnt, lat_cnt_nxt;
  logic [STARVE_W-1:0] starve_cnt, starve_cnt_nxt;
  logic                grant_valid, grant_owner;
  logic                issue, cap_if, cap_d;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .STARVE_W   (STARVE_W)
  ) u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .starve_cnt  (starve_cnt),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Next-state logic: grant in IDLE, count latency in WAIT, ack in DONE.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    issue          = 1'b0;
    cap_if         = 1'b0;
    cap_d          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          issue       = 1'b1;
          owner_nxt   = grant_owner;
          lat_cnt_nxt = LAT_W'(1);
          state_nxt   = ST_WAIT;
          // Only data grants made while fetch waits count toward starvation.
          if ((grant_owner == OWNER_D) && if_req) begin
            if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
              starve_cnt_nxt = starve_cnt + STARVE_W'(1);
            end
          end else begin
            starve_cnt_nxt = '0;
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_W'(MEM_LAT)) begin
          cap_if    = (owner == OWNER_IF);
          cap_d     = (owner == OWNER_D);
          state_nxt = ST_DONE;
        end else begin
          lat_cnt_nxt = lat_cnt + LAT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and per-owner read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWNER_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (cap_if) begin
        if_rdata <= mem_rdata;
      end
      if (cap_d) begin
        d_rdata <= mem_rdata;
      end
    end
  end

  // Memory bus mux, acks from DONE/owner, and stage stalls.
  always_comb begin
    mem_en    = issue & ~rst;
    mem_we    = mem_en & (grant_owner == OWNER_D) & d_we;
    mem_addr  = (grant_owner == OWNER_D) ? d_addr : if_addr;
    mem_wdata = d_wdata;
    if_ack    = (state == ST_DONE) & (owner == OWNER_IF) & ~rst;
    d_ack     = (state == ST_DONE) & (owner == OWNER_D) & ~rst;
    stall_if  = if_req & ~if_ack;
    stall_mem = d_req & ~d_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiter instances (MEM_LAT=1/STARVE_MAX=4 and
// MEM_LAT=3/STARVE_MAX=0) driven by directed, back-to-back and random requests.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned NW       = 32;
  localparam int          NSTEP    = 5;
  localparam int          HOLD_CYC = 80;
  localparam int          RAND_CYC = 1500;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } txn_t;

  typedef struct packed {
    logic        if_on;
    logic [31:0] if_a;
    logic        d_on;
    logic        we;
    logic [31:0] d_a;
    logic [31:0] wd;
    logic        rst_after;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done0 = 1'b0;
  bit done1 = 1'b0;

  logic        rst [2];
  logic        if_req [2], if_ack [2], d_req [2], d_we [2], d_ack [2];
  logic        mem_en [2], mem_we [2], stall_if [2], stall_mem [2];
  logic [31:0] if_addr [2], if_rdata [2], d_addr [2], d_wdata [2], d_rdata [2];
  logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got 0x%h, expected 0x%h", name, inst, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, NW - 1)) << 2;
  endfunction

  // Directed opening: load, store, fetch, collision, reset during a load.
  function automatic step_t get_step(input int i);
    step_t s;
    s = '0;
    case (i)
      0: begin s.d_on = 1'b1; s.d_a = 32'h10; end
      1: begin s.d_on = 1'b1; s.we = 1'b1; s.d_a = 32'h20; s.wd = 32'h5A5A5A5A; end
      2: begin s.if_on = 1'b1; s.if_a = 32'h40; end
      3: begin s.if_on = 1'b1; s.if_a = 32'h44; s.d_on = 1'b1; s.d_a = 32'h20; end
      default: begin s.d_on = 1'b1; s.d_a = 32'h28; s.rst_after = 1'b1; end
    endcase
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned LAT  = (g == 0) ? 1 : 3;
    localparam int unsigned SMAX = (g == 0) ? 4 : 0;

    logic [31:0] mem [NW];
    bit          written [NW];
    logic [31:0] rd_pipe [LAT];

    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_rdata  (if_rdata[g]),
      .if_ack    (if_ack[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_rdata   (d_rdata[g]),
      .d_ack     (d_ack[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .stall_if  (stall_if[g]),
      .stall_mem (stall_mem[g])
    );

    // Fixed-latency memory; garbage on the read pipe when not accessed.
    always @(posedge clk) begin
      if (mem_en[g]) begin
        rd_pipe[0] <= written[mem_addr[g][6:2]] ? mem[mem_addr[g][6:2]]
                                                 : init_word(int'(mem_addr[g][6:2]));
        if (mem_we[g]) begin
          mem[mem_addr[g][6:2]]     <= mem_wdata[g];
          written[mem_addr[g][6:2]] <= 1'b1;
        end
      end else begin
        rd_pipe[0] <= $urandom;
      end
      for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata[g] = rd_pipe[LAT-1];

    // Requesters, reference model and scoreboard for this instance.
    initial begin : p_main
      txn_t        q[$];
      txn_t        t;
      step_t       s;
      logic [31:0] sh [NW];
      int          cyc, next_free, step, phase, phase_cyc, idx;
      int unsigned starve;
      bit          if_pend, d_pend, do_rst, rst_now, rst_armed, d_known, is_d, exp_ia, exp_da;
      logic [31:0] exp_ir, exp_dr;

      for (int i = 0; i < int'(NW); i++) sh[i] = init_word(i);
      cyc = 0; next_free = 0; step = 0; phase = 0; phase_cyc = 0; starve = 0;
      if_pend = 0; d_pend = 0; do_rst = 0; rst_armed = 0; d_known = 1;
      exp_ir = '0; exp_dr = '0;
      rst[g] = 1'b1; if_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 1'b0;
      if_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;

      while (phase < 4) begin
        @(posedge clk);
        #1;
        rst_now = (cyc < 2) || do_rst;
        do_rst  = 0;
        if (!rst_now) begin
          case (phase)
            0: begin
              if (!if_pend && !d_pend) begin
                if (step < NSTEP) begin
                  s = get_step(step);
                  step++;
                  if (s.if_on) begin if_pend = 1; if_addr[g] = s.if_a; end
                  if (s.d_on) begin
                    d_pend = 1; d_we[g] = s.we; d_addr[g] = s.d_a; d_wdata[g] = s.wd;
                  end
                  rst_armed = s.rst_after;
                end else begin
                  phase = 1; phase_cyc = 0;
                end
              end
            end
            1, 2: begin
              if (!if_pend && (phase == 1 || $urandom_range(0, 2) == 0)) begin
                if_pend = 1; if_addr[g] = rand_addr();
              end
              if (!d_pend && (phase == 1 || $urandom_range(0, 2) == 0)) begin
                d_pend = 1; d_we[g] = 1'($urandom_range(0, 1));
                d_addr[g] = rand_addr(); d_wdata[g] = $urandom;
              end
              phase_cyc++;
              if (phase == 1 && phase_cyc == HOLD_CYC) begin phase = 2; phase_cyc = 0; end
              else if (phase == 2 && phase_cyc == RAND_CYC) begin phase = 3; phase_cyc = 0; end
            end
            default: begin
              phase_cyc++;
              if ((!if_pend && !d_pend) || phase_cyc > 400) phase = 4;
            end
          endcase
        end
        rst[g] = rst_now; if_req[g] = if_pend; d_req[g] = d_pend;

        @(negedge clk);
        if (rst_now) begin
          check("mem_en_in_reset", g, 32'(mem_en[g]), 32'd0);
          check("mem_we_in_reset", g, 32'(mem_we[g]), 32'd0);
          check("if_ack_in_reset", g, 32'(if_ack[g]), 32'd0);
          check("d_ack_in_reset", g, 32'(d_ack[g]), 32'd0);
          q.delete();
          next_free = cyc + 1; starve = 0;
          exp_ir = '0; exp_dr = '0; d_known = 1;
        end else begin
          exp_ia = 0; exp_da = 0;
          if (q.size() > 0 && q[0].due == cyc) begin
            t = q.pop_front();
            if (t.is_d) begin exp_da = 1; exp_dr = t.data; d_known = !t.we; end
            else begin exp_ia = 1; exp_ir = t.data; end
          end
          check("if_ack", g, 32'(if_ack[g]), 32'(exp_ia));
          check("d_ack", g, 32'(d_ack[g]), 32'(exp_da));
          check("stall_if", g, 32'(stall_if[g]), 32'(if_req[g] & ~exp_ia));
          check("stall_mem", g, 32'(stall_mem[g]), 32'(d_req[g] & ~exp_da));
          check("if_rdata", g, if_rdata[g], exp_ir);
          if (d_known) check("d_rdata", g, d_rdata[g], exp_dr);

          if (cyc >= next_free && (if_req[g] || d_req[g])) begin
            is_d = d_req[g] && !(if_req[g] && SMAX != 0 && starve == SMAX);
            if (is_d && if_req[g]) starve = (starve < SMAX) ? starve + 1 : starve;
            else starve = 0;
            idx    = is_d ? int'(d_addr[g][6:2]) : int'(if_addr[g][6:2]);
            t.is_d = is_d;
            t.we   = is_d && d_we[g];
            t.addr = is_d ? d_addr[g] : if_addr[g];
            t.data = sh[idx];
            if (t.we) sh[idx] = d_wdata[g];
            t.due = cyc + int'(LAT) + 1;
            q.push_back(t);
            next_free = cyc + int'(LAT) + 2;
            check("mem_en_grant", g, 32'(mem_en[g]), 32'd1);
            check("mem_addr", g, mem_addr[g], t.addr);
            check("mem_we", g, 32'(mem_we[g]), 32'(t.we));
            if (t.we) check("mem_wdata", g, mem_wdata[g], d_wdata[g]);
            if (rst_armed && is_d) begin do_rst = 1; rst_armed = 0; end
          end else begin
            check("mem_en_idle", g, 32'(mem_en[g]), 32'd0);
          end
        end
        if (if_ack[g] === 1'b1) if_pend = 0;
        if (d_ack[g] === 1'b1) d_pend = 0;
        cyc++;
      end

      check("drain_pending", g, 32'({if_pend, d_pend}), 32'd0);
      check("drain_queue", g, 32'(q.size()), 32'd0);
      if (g == 0) done0 = 1'b1;
      else done1 = 1'b1;
    end
  end

  initial begin
    wait (done0 && done1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
